// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions used by the fetch stage: bubble encoding,
// default reset PC, fetch-FSM state encoding and PC increment helper.
package riscv_pkg;

    // addi x0, x0, 0 -- the canonical pipeline bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default fetch address after reset
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // Fetch FSM: REQ issues a request, WAIT has one request outstanding,
    // HOLD parks a returned instruction in the skid buffer during a stall.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // Sequential next PC; plain 32-bit add, so 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/grant/response handshake.
// master = fetch stage, slave = instruction memory.
interface if_stage_if;

    logic        ImemReq;     // fetch request valid
    logic [31:0] ImemAddr;    // fetch address
    logic        ImemGnt;     // memory accepts the request this cycle
    logic        ImemRValid;  // response valid
    logic [31:0] ImemRData;   // response instruction

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemGnt,
        input  ImemRValid,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemGnt,
        output ImemRValid,
        output ImemRData
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC, PC+4 and valid bit.
// Priority: flush (bubble) > stall (hold) > load > bubble.
// A bubble rewrites only InstrD/ValidD; the PC fields keep their value.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;

    // Pipeline register update with flush/stall/load priority
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else if (stall_i) begin
            instr_q    <= instr_q;
            valid_q    <= valid_q;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end else begin
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register for the 5-stage RV32I core.
// Owns PCF, runs a REQ/WAIT/HOLD handshake FSM against variable-latency
// instruction memory, parks stalled responses in a one-entry skid buffer
// and kills in-flight fetches on EX redirects.
// Optional build macro: IF_PERF_CNT_EN adds FetchCnt/KillCnt counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              StallF,
    input  logic              FlushD,
    input  logic              PCSrcE,
    input  logic [31:0]       PCTargetE,
    if_stage_if.master        imem,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    output logic              FetchBusy
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0]       FetchCnt,
    output logic [31:0]       KillCnt
`endif
);

    import riscv_pkg::*;

    fetch_state_e state_q;
    logic [31:0]  pcf_q;
    logic         kill_q;
    logic [31:0]  skid_instr_q;
    logic [31:0]  skid_pc_q;

    logic         in_req;
    logic         in_wait;
    logic         in_hold;
    logic         rsp_live;
    logic         deliver_wait;
    logic         deliver_hold;
    logic         new_valid_d;
    logic         bubble_d;
    logic [31:0]  new_instr_d;
    logic [31:0]  new_pc_d;
    logic [31:0]  new_pc_plus4_d;

    assign in_req   = (state_q == S_REQ);
    assign in_wait  = (state_q == S_WAIT);
    assign in_hold  = (state_q == S_HOLD);

    // A response that is not being thrown away because of an earlier redirect
    assign rsp_live = in_wait & imem.ImemRValid & ~kill_q;

    // A redirect squashes whatever would have entered decode this cycle
    assign bubble_d     = FlushD | PCSrcE;
    assign deliver_wait = rsp_live & ~StallF & ~PCSrcE;
    assign deliver_hold = in_hold  & ~StallF & ~PCSrcE;
    assign new_valid_d  = deliver_wait | deliver_hold;

    // Select the instruction source for IF/ID: skid buffer in HOLD, memory otherwise
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        new_instr_d = imem.ImemRData;
        new_pc_d    = pcf_q;
        if (in_hold) begin
            new_instr_d = skid_instr_q;
            new_pc_d    = skid_pc_q;
        end
    end

    assign new_pc_plus4_d = pc_plus4(new_pc_d);

    // Fetch FSM: PCF, outstanding-request kill flag and skid buffer
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            kill_q       <= 1'b0;
            // NOTE: the skid is reset too, although HOLD already marks it valid; this keeps X out of sim.
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (PCSrcE) begin
                        pcf_q <= PCTargetE;
                        // A grant taken in the redirect cycle fetches the old
                        // path; its response must be dropped.
                        if (imem.ImemGnt) begin
                            state_q <= S_WAIT;
                            kill_q  <= 1'b1;
                        end
                    end else if (imem.ImemGnt) begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (PCSrcE) begin
                        pcf_q <= PCTargetE;
                        if (imem.ImemRValid) begin
                            state_q <= S_REQ;
                            kill_q  <= 1'b0;
                        end else begin
                            kill_q  <= 1'b1;
                        end
                    end else if (imem.ImemRValid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (StallF) begin
                            skid_instr_q <= imem.ImemRData;
                            skid_pc_q    <= pcf_q;
                            state_q      <= S_HOLD;
                        end else begin
                            pcf_q   <= pc_plus4(pcf_q);
                            state_q <= S_REQ;
                        end
                    end
                end

                S_HOLD: begin
                    if (PCSrcE) begin
                        pcf_q   <= PCTargetE;
                        state_q <= S_REQ;
                    end else if (!StallF) begin
                        pcf_q   <= pc_plus4(pcf_q);
                        state_q <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    // Request is gated by Reset so memory never sees a fetch during reset
    assign imem.ImemReq  = in_req & ~Reset;
    assign imem.ImemAddr = pcf_q;

    assign FetchBusy = ~rsp_live & ~(in_hold & ~StallF);

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (CLK),
        .rst        (Reset),
        .stall_i    (StallF),
        .flush_i    (bubble_d),
        .load_i     (new_valid_d),
        .instr_i    (new_instr_d),
        .pc_i       (new_pc_d),
        .pc_plus4_i (new_pc_plus4_d),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] kill_cnt_q;
    logic        fetch_evt;
    logic        discard_evt;

    // A load reaches decode only when FlushD does not override it
    assign fetch_evt   = new_valid_d & ~FlushD;
    // Dropped responses: killed or redirected in WAIT, or a skid dropped in HOLD
    assign discard_evt = (in_wait & imem.ImemRValid & (kill_q | PCSrcE))
                       | (in_hold & PCSrcE);

    // Performance counters
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            if (fetch_evt)   fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (discard_evt) kill_cnt_q  <= kill_cnt_q + 32'd1;
        end
    end

    assign FetchCnt = fetch_cnt_q;
    assign KillCnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage. Each vector holds the inputs
// for one cycle and the outputs expected just before the next rising edge.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        Reset;
    logic        StallF;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FetchBusy;
`ifdef IF_PERF_CNT_EN
    logic [31:0] FetchCnt;
    logic [31:0] KillCnt;
`endif

    if_stage_if imem ();

    if_stage dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .StallF    (StallF),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (imem),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .FetchBusy (FetchBusy)
`ifdef IF_PERF_CNT_EN
       ,.FetchCnt  (FetchCnt),
        .KillCnt   (KillCnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [31:0] target;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        valid;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pcd,
                              input logic [31:0] p4, input logic valid, input logic busy);
        check({tag, ".req"},   {31'd0, imem.ImemReq}, {31'd0, req});
        check({tag, ".addr"},  imem.ImemAddr, addr);
        check({tag, ".instr"}, InstrD, instr);
        check({tag, ".pcd"},   PCD, pcd);
        check({tag, ".pc4"},   PCPlus4D, p4);
        check({tag, ".valid"}, {31'd0, ValidD}, {31'd0, valid});
        check({tag, ".busy"},  {31'd0, FetchBusy}, {31'd0, busy});
    endtask

    function automatic vec_t mk(logic stall, logic flush, logic pcsrc, logic [31:0] target,
                                logic gnt, logic rv, logic [31:0] rdata,
                                logic req, logic [31:0] addr, logic [31:0] instr,
                                logic [31:0] pcd, logic [31:0] p4, logic valid, logic busy);
        vec_t v;
        v.stall = stall; v.flush = flush; v.pcsrc = pcsrc; v.target = target;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.req = req; v.addr = addr; v.instr = instr; v.pcd = pcd; v.p4 = p4;
        v.valid = valid; v.busy = busy;
        return v;
    endfunction

    task automatic drive_idle();
        StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
        imem.ImemGnt = 1'b0; imem.ImemRValid = 1'b0; imem.ImemRData = 32'd0;
    endtask

    initial begin
        //           stall flush pcsrc target        gnt rv rdata           req addr          instr         pcd           p4            v  busy
        // Back-to-back fetches, one-cycle memory latency
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,        NOP,          32'h0,        32'h0,        0, 1)); // 0
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0050_0093,  0, 32'h0,        NOP,          32'h0,        32'h0,        0, 0)); // 1
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h4,        32'h0050_0093,32'h0,        32'h4,        1, 1)); // 2
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0010_0113,  0, 32'h4,        NOP,          32'h0,        32'h4,        0, 0)); // 3
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h8,        32'h0010_0113,32'h4,        32'h8,        1, 1)); // 4
        // Stall while the response at 0x8 returns -> skid, hold, then release
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h0020_0193,  0, 32'h8,        NOP,          32'h4,        32'h8,        0, 0)); // 5
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h8,        NOP,          32'h4,        32'h8,        0, 1)); // 6
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h8,        NOP,          32'h4,        32'h8,        0, 1)); // 7
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h8,        NOP,          32'h4,        32'h8,        0, 0)); // 8
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'hC,        32'h0020_0193,32'h8,        32'hC,        1, 1)); // 9
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'hC,        NOP,          32'h8,        32'hC,        0, 1)); // 10
        // Redirect in WAIT, then a late response that must be dropped
        vecs.push_back(mk(0, 0, 1, 32'h100,       0, 0, 32'h0,          0, 32'hC,        NOP,          32'h8,        32'hC,        0, 1)); // 11
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF,  0, 32'h100,      NOP,          32'h8,        32'hC,        0, 1)); // 12
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h100,      NOP,          32'h8,        32'hC,        0, 1)); // 13
        // Redirect and response in the same cycle
        vecs.push_back(mk(0, 0, 1, 32'h200,       0, 1, 32'h1234_5678,  0, 32'h100,      NOP,          32'h8,        32'hC,        0, 0)); // 14
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h200,      NOP,          32'h8,        32'hC,        0, 1)); // 15
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h200,      NOP,          32'h8,        32'hC,        0, 1)); // 16
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0030_8213,  0, 32'h200,      NOP,          32'h8,        32'hC,        0, 0)); // 17
        // Flush beats stall
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h204,      32'h0030_8213,32'h200,      32'h204,      1, 1)); // 18
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h204,      NOP,          32'h200,      32'h204,      0, 1)); // 19
        // Redirect in REQ with same-cycle grant -> that fetch is killed
        vecs.push_back(mk(0, 0, 1, 32'h300,       1, 0, 32'h0,          1, 32'h204,      NOP,          32'h200,      32'h204,      0, 1)); // 20
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'hBADC_0FFE,  0, 32'h300,      NOP,          32'h200,      32'h204,      0, 1)); // 21
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h300,      NOP,          32'h200,      32'h204,      0, 1)); // 22
        // Jump to the top of the address space; PC+4 wraps to 0
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,          1, 32'h300,      NOP,          32'h200,      32'h204,      0, 1)); // 23
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'hFFFF_FFFC,NOP,          32'h200,      32'h204,      0, 1)); // 24
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_0533,  0, 32'hFFFF_FFFC,NOP,          32'h200,      32'h204,      0, 0)); // 25
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,        32'h0000_0533,32'hFFFF_FFFC,32'h0,        1, 1)); // 26
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h00A0_0593,  0, 32'h0,        NOP,          32'hFFFF_FFFC,32'h0,        0, 0)); // 27
        // Grant with IF/ID stalled: leaves the FSM in WAIT with a valid instruction in decode
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h4,        32'h00A0_0593,32'h0,        32'h4,        1, 1)); // 28

        Reset = 1'b1;
        drive_idle();

        // Reset state, request gated while Reset is high
        @(negedge CLK);
        #1;
        check_outs("reset", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b1);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            StallF           = vecs[i].stall;
            FlushD           = vecs[i].flush;
            PCSrcE           = vecs[i].pcsrc;
            PCTargetE        = vecs[i].target;
            imem.ImemGnt     = vecs[i].gnt;
            imem.ImemRValid  = vecs[i].rv;
            imem.ImemRData   = vecs[i].rdata;
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].instr,
                       vecs[i].pcd, vecs[i].p4, vecs[i].valid, vecs[i].busy);
        end

        // Reset asserted mid-WAIT (PCF=0x4, valid instruction in decode)
        @(negedge CLK);
        drive_idle();
        Reset = 1'b1;
        #1;
        check_outs("midrst", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b1);

        // Late response arrives while still in reset and just after release
        @(negedge CLK);
        imem.ImemRValid = 1'b1;
        imem.ImemRData  = 32'hCAFE_0001;
        #1;
        check_outs("rsthold", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b1);

        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check_outs("rstrel", 1'b1, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b1);

        @(negedge CLK);
        imem.ImemRValid = 1'b0;
        #1;
        check_outs("late", 1'b1, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
